// File: rtl/cga_vram_arbiter.sv
// CGA framebuffer arbiter: slots ISA CPU accesses into the video RAM between
// sequencer fetch cycles, forcing a grant (with a snow pulse) if video starves the CPU.
module cga_vram_arbiter #(
  parameter int unsigned USE_BUS_WAIT = 1,
  parameter logic [7:0]  MAX_WAIT     = 8'd64
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [14:0] bus_a,
  input  logic [7:0]  bus_d,
  input  logic        bus_mem_cs,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  output logic [7:0]  bus_out_mem,
  output logic        bus_rdy,
  input  logic        vram_read,
  input  logic [18:0] video_addr,
  output logic [18:0] ram_a,
  output logic        ram_we_l,
  input  logic [7:0]  ram_d,
  output logic [7:0]  ram_wd,
  output logic        cpu_access,
  output logic        snow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SLOT,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [1:0]  memr_sync_q;
  logic [1:0]  memw_sync_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        forced_q;
  logic        snow_q;
  logic        wr_q;
  logic [14:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;

  logic memr_s;
  logic memw_s;
  logic req_start;
  logic cpu_phase;
  logic abort;
  logic cpu_owns;
  logic wait_req;

  assign memr_s    = memr_sync_q[1];
  assign memw_s    = memw_sync_q[1];
  assign req_start = bus_mem_cs && (!memr_s || !memw_s);
  assign cnt_d     = cnt_q + 8'd1;

  assign cpu_phase = (state_q == S_ACCESS) || (state_q == S_CAPTURE);
  // An unforced CPU cycle yields to video in the same cycle the fetch slot appears.
  assign abort     = cpu_phase && vram_read && !forced_q;
  assign cpu_owns  = cpu_phase && !abort;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= S_IDLE;
      memr_sync_q <= 2'b11;
      memw_sync_q <= 2'b11;
      cnt_q       <= 8'd0;
      forced_q    <= 1'b0;
      snow_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 15'd0;
      wdata_q     <= 8'd0;
      rdata_q     <= 8'd0;
    end else begin
      memr_sync_q <= {memr_sync_q[0], bus_memr_l};
      memw_sync_q <= {memw_sync_q[0], bus_memw_l};
      snow_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_start) begin
            state_q <= S_WAIT_SLOT;
            cnt_q   <= 8'd0;
            addr_q  <= bus_a;
            wdata_q <= bus_d;
            wr_q    <= !memw_s;
          end
        end
        S_WAIT_SLOT: begin
          if (!vram_read) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == MAX_WAIT) begin
              state_q  <= S_ACCESS;
              forced_q <= 1'b1;
              snow_q   <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          state_q <= abort ? S_WAIT_SLOT : S_CAPTURE;
        end
        S_CAPTURE: begin
          if (abort) begin
            state_q <= S_WAIT_SLOT;
          end else begin
            if (!wr_q) rdata_q <= ram_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if ((memr_s && memw_s) || !bus_mem_cs) begin
            state_q  <= S_IDLE;
            forced_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_a       = cpu_owns ? {4'h0, addr_q} : video_addr;
  assign cpu_access  = cpu_owns;
  assign ram_we_l    = !((state_q == S_ACCESS) && wr_q && !abort);
  assign ram_wd      = wdata_q;
  assign bus_out_mem = rdata_q;
  assign snow        = snow_q;

  // Wait states come from the raw strobe so the ISA cycle is held from its first clock.
  assign wait_req = reset_l && bus_mem_cs && (!bus_memr_l || !bus_memw_l)
                    && (state_q != S_DONE);
  assign bus_rdy  = (USE_BUS_WAIT != 0) ? !wait_req : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Bench for cga_vram_arbiter: directed scenarios plus randomized transactions
// checked against a cycle-arithmetic model of when the CPU gets the RAM.
module tb_cga_vram_arbiter;

  localparam int MAXW = 64;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [14:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_mem_cs;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic [7:0]  bus_out_mem;
  logic        bus_rdy;
  logic        vram_read;
  logic [18:0] video_addr;
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_d;
  logic [7:0]  ram_wd;
  logic        cpu_access;
  logic        snow;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  int          wr_cyc[$];
  logic [18:0] wr_adr[$];
  logic [7:0]  wr_dat[$];
  int          snow_cyc[$];
  logic [7:0]  rd_exp = 8'h00;

  function automatic logic [7:0] ram_hash(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A;
  endfunction

  assign ram_d = ram_hash(ram_a);

  cga_vram_arbiter #(.USE_BUS_WAIT(1), .MAX_WAIT(8'd64)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .bus_a      (bus_a),
    .bus_d      (bus_d),
    .bus_mem_cs (bus_mem_cs),
    .bus_memr_l (bus_memr_l),
    .bus_memw_l (bus_memw_l),
    .bus_out_mem(bus_out_mem),
    .bus_rdy    (bus_rdy),
    .vram_read  (vram_read),
    .video_addr (video_addr),
    .ram_a      (ram_a),
    .ram_we_l   (ram_we_l),
    .ram_d      (ram_d),
    .ram_wd     (ram_wd),
    .cpu_access (cpu_access),
    .snow       (snow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!ram_we_l) begin
      wr_cyc.push_back(cyc);
      wr_adr.push_back(ram_a);
      wr_dat.push_back(ram_wd);
    end
    if (snow) snow_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cyc.delete();
    wr_adr.delete();
    wr_dat.delete();
    snow_cyc.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    video_addr = 19'($urandom);
  endtask

  // ab: 0 none, 1 video steals the ACCESS cycle, 2 video steals the CAPTURE cycle
  task automatic run_txn(input bit wr, input logic [14:0] addr, input logic [7:0] data,
                         input int n, input int ab, input bit both);
    int          c0;
    int          a_fin;
    int          ab_cyc;
    int          exp_c[$];
    bit          exp_snow;
    logic [18:0] cpu_a;
    step();
    c0    = cyc;
    clear_mon();
    cpu_a = {4'h0, addr};
    bus_a = addr;
    bus_d = data;
    bus_mem_cs = 1'b1;
    bus_memw_l = !wr;
    bus_memr_l = wr ? !both : 1'b0;
    ab_cyc = -1;
    if (ab == 1) begin
      ab_cyc = c0 + 4 + n;
      a_fin  = c0 + 6 + n;
    end else if (ab == 2) begin
      ab_cyc = c0 + 5 + n;
      a_fin  = c0 + 7 + n;
    end else if (n >= MAXW) begin
      a_fin = c0 + 3 + MAXW;
    end else begin
      a_fin = c0 + 4 + n;
    end
    for (int k = c0; k <= a_fin + 2; k++) begin
      if (k != c0) step();
      vram_read = (k <= c0 + 2 + n) || (k == ab_cyc);
      @(negedge clk);
      if (k == c0 + 1) begin
        chk("idle_rdy", 32'(bus_rdy), 0);
        chk("idle_ram_a", 32'(ram_a), 32'(video_addr));
        chk("idle_cpu", 32'(cpu_access), 0);
      end
      if (k == ab_cyc) begin
        chk("abort_we", 32'(ram_we_l), 1);
        chk("abort_ram_a", 32'(ram_a), 32'(video_addr));
        chk("abort_cpu", 32'(cpu_access), 0);
      end
      if (k == a_fin) begin
        chk("acc_cpu", 32'(cpu_access), 1);
        chk("acc_ram_a", 32'(ram_a), 32'(cpu_a));
        chk("acc_we", 32'(ram_we_l), 32'(!wr));
        if (wr) chk("acc_wd", 32'(ram_wd), 32'(data));
      end
      if (k == a_fin + 1) begin
        chk("cap_we", 32'(ram_we_l), 1);
        chk("cap_ram_a", 32'(ram_a), 32'(cpu_a));
        chk("cap_rdy", 32'(bus_rdy), 0);
      end
      if (k == a_fin + 2) begin
        if (!wr) rd_exp = ram_hash(cpu_a);
        chk("done_rdy", 32'(bus_rdy), 1);
        chk("done_cpu", 32'(cpu_access), 0);
        chk("done_rd", 32'(bus_out_mem), 32'(rd_exp));
      end
    end
    step();
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b1;
    vram_read  = 1'b0;
    repeat (5) step();
    @(negedge clk);
    if (wr) begin
      if (ab == 2) exp_c.push_back(c0 + 4 + n);
      exp_c.push_back(a_fin);
    end
    chk("wr_count", wr_cyc.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < wr_cyc.size(); i++) begin
      chk("wr_cyc", wr_cyc[i], exp_c[i]);
      chk("wr_adr", 32'(wr_adr[i]), 32'(cpu_a));
      chk("wr_dat", 32'(wr_dat[i]), 32'(data));
    end
    exp_snow = (ab == 0) && (n >= MAXW);
    chk("snow_count", snow_cyc.size(), exp_snow ? 1 : 0);
    if (exp_snow && snow_cyc.size() > 0) chk("snow_cyc", snow_cyc[0], a_fin);
    chk("hold_rd", 32'(bus_out_mem), 32'(rd_exp));
    chk("after_rdy", 32'(bus_rdy), 1);
  endtask

  initial begin
    int r;
    int c0;
    reset_l    = 1'b0;
    bus_a      = 15'd0;
    bus_d      = 8'd0;
    bus_mem_cs = 1'b1;
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b0;
    vram_read  = 1'b0;
    video_addr = 19'h51234;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(bus_rdy), 1);
    chk("rst_ram_a", 32'(ram_a), 32'(video_addr));
    chk("rst_we", 32'(ram_we_l), 1);
    chk("rst_cpu", 32'(cpu_access), 0);
    chk("rst_snow", 32'(snow), 0);
    chk("rst_rd", 32'(bus_out_mem), 0);
    bus_memw_l = 1'b1;
    bus_mem_cs = 1'b0;
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("post_rst_ram_a", 32'(ram_a), 32'(video_addr));
    chk("post_rst_rdy", 32'(bus_rdy), 1);

    run_txn(1'b1, 15'h0123, 8'hA5, 0, 0, 1'b0);
    run_txn(1'b0, 15'h0066, 8'h00, 0, 0, 1'b0);
    run_txn(1'b1, 15'h7F00, 8'h3D, 10, 0, 1'b0);
    run_txn(1'b1, 15'h1111, 8'hC3, 0, 1, 1'b0);
    run_txn(1'b0, 15'h2468, 8'h00, 3, 2, 1'b0);
    run_txn(1'b1, 15'h0ABC, 8'h5E, 80, 0, 1'b1);
    run_txn(1'b0, 15'h4321, 8'h00, 63, 0, 1'b0);
    run_txn(1'b1, 15'h6000, 8'h99, 64, 0, 1'b0);

    step();
    c0 = cyc;
    clear_mon();
    bus_a      = 15'h2A5A;
    bus_d      = 8'h77;
    bus_mem_cs = 1'b1;
    bus_memw_l = 1'b0;
    vram_read  = 1'b1;
    repeat (6) step();
    reset_l = 1'b0;
    #1;
    chk("rmid_we", 32'(ram_we_l), 1);
    chk("rmid_cpu", 32'(cpu_access), 0);
    chk("rmid_snow", 32'(snow), 0);
    chk("rmid_rd", 32'(bus_out_mem), 0);
    chk("rmid_rdy", 32'(bus_rdy), 1);
    chk("rmid_ram_a", 32'(ram_a), 32'(video_addr));
    rd_exp = 8'h00;
    repeat (3) step();
    vram_read = 1'b0;
    reset_l   = 1'b1;
    r = cyc;
    for (int k = r; k <= r + 6; k++) begin
      if (k != r) step();
      @(negedge clk);
      if (k == r + 4) begin
        chk("rnew_we", 32'(ram_we_l), 0);
        chk("rnew_ram_a", 32'(ram_a), 32'({4'h0, 15'h2A5A}));
        chk("rnew_wd", 32'(ram_wd), 32'h77);
      end
      if (k == r + 6) chk("rnew_rdy", 32'(bus_rdy), 1);
    end
    chk("rmid_wr_count", wr_cyc.size(), 1);
    if (wr_cyc.size() > 0) chk("rmid_wr_cyc", wr_cyc[0], r + 4);
    if (c0 > r) chk("rmid_order", c0, r);
    step();
    bus_memw_l = 1'b1;
    repeat (5) step();

    for (int t = 0; t < 14; t++) begin
      bit wr_r;
      int n_r;
      int ab_r;
      wr_r = 1'($urandom_range(0, 1));
      n_r  = int'($urandom_range(0, 72));
      ab_r = (n_r < MAXW) ? int'($urandom_range(0, 2)) : 0;
      run_txn(wr_r, 15'($urandom), 8'($urandom), n_r, ab_r, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cga_vram_arbiter.md
CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

Interface
REQ-001 Parameter USE_BUS_WAIT, default 1, meaning 1 = drive ISA wait states on bus_rdy and 0 = bus_rdy tied to 1.
REQ-002 Parameter MAX_WAIT, default 8'd64, meaning the WAIT_SLOT cycle count after which the CPU is granted regardless of video.
REQ-003 clk  in  1  system clock; the sole clock; all state changes on its rising edge.
REQ-004 reset_l  in  1  asynchronous, active-low reset.
REQ-005 bus_a  in  15  CPU offset within the 32K framebuffer window.
REQ-006 bus_d  in  8  CPU write data.
REQ-007 bus_mem_cs  in  1  framebuffer window decode, already qualified by ~bus_aen.
REQ-008 bus_memr_l, bus_memw_l  in  1 each  raw ISA memory strobes, active-low.
REQ-009 bus_out_mem  out  8  CPU read data.
REQ-010 bus_rdy  out  1  ISA ready; 0 = insert wait state.
REQ-011 vram_read  in  1  sequencer video-fetch slot; 1 = video owns the RAM this cycle.
REQ-012 video_addr  in  19  video fetch address.
REQ-013 ram_a  out  19  RAM address.
REQ-014 ram_we_l  out  1  RAM write enable, active-low.
REQ-015 ram_d  in  8  RAM read data.
REQ-016 ram_wd  out  8  RAM write data.
REQ-017 cpu_access  out  1  1 while the CPU owns ram_a.
REQ-018 snow  out  1  one-cycle pulse on each forced grant.

Function
REQ-019 Strobes shall pass through 2-flop synchronizers (reset value 1); a request shall start on the first clk where a synchronized strobe is 0, bus_mem_cs=1 and the state is IDLE.
REQ-020 At request start the block shall latch bus_a, bus_d and op (write if memw, else read); memw shall win if both strobes are asserted.
REQ-021 States: IDLE -> WAIT_SLOT -> ACCESS -> CAPTURE -> DONE -> IDLE.
REQ-022 IDLE: on request start, go to WAIT_SLOT and clear the 8-bit wait counter.
REQ-023 WAIT_SLOT: if vram_read=0, go to ACCESS.
REQ-024 WAIT_SLOT: otherwise increment the wait counter; when it equals MAX_WAIT, go to ACCESS with the forced flag set and pulse snow for 1 cycle.
REQ-025 ACCESS (1 cycle): ram_a={4'h0,latched addr}, cpu_access=1, ram_wd=latched data, ram_we_l=0 only for writes.
REQ-026 CAPTURE (1 cycle): ram_a still CPU, ram_we_l=1; for reads, bus_out_mem<=ram_d at the end of the cycle; then go to DONE.
REQ-027 Abort: if vram_read=1 in ACCESS or CAPTURE with the forced flag clear, ram_a shall revert to video_addr that cycle and ram_we_l shall be 1; the state shall return to WAIT_SLOT with the counter kept, and the access shall be retried in full.
REQ-028 With the forced flag set, vram_read shall be ignored until DONE.
REQ-029 DONE: remain until both synchronized strobes are 1 or bus_mem_cs=0, then go to IDLE and clear the forced flag.
REQ-030 bus_rdy (USE_BUS_WAIT=1) shall be combinational: 0 when bus_mem_cs=1, a raw strobe is 0 and the state is not DONE; otherwise 1.
REQ-031 ram_a shall equal video_addr and cpu_access shall be 0 in every state other than ACCESS and CAPTURE.
REQ-032 bus_out_mem shall hold its value until the next completed read.
REQ-033 The latency from request start to DONE shall be 3 clk cycles when vram_read=0 throughout.

Reset
REQ-034 While reset_l=0, asynchronously set: state=IDLE, counter=0, forced=0, synchronizers=1, bus_out_mem=8'h00, ram_we_l=1, cpu_access=0, snow=0.
REQ-035 The ram_a mux shall select video_addr during reset, and bus_rdy shall be 1 during reset.
REQ-036 Reset asserted mid-access shall drop any write in progress with no RAM write; an open strobe after release shall be treated as a new request.

Verification
REQ-037 Write bus_a=15'h0123, bus_d=8'hA5, vram_read=0 -> one cycle with ram_we_l=0 and ram_a=19'h00123, ram_wd=8'hA5; bus_rdy=1 after 3 cycles plus synchronizer delay.
REQ-038 Read with ram_d=8'h3C and vram_read=0 -> bus_out_mem=8'h3C in DONE; bus_rdy goes 0 then 1; ram_we_l stays 1.
REQ-039 vram_read=1 for 10 cycles then 0 -> no ram_we_l pulse during those cycles; access completes afterwards; snow never pulses.
REQ-040 vram_read rises in ACCESS of a write -> ram_we_l returns to 1 that cycle; exactly one later completed write.
REQ-041 vram_read held at 1, MAX_WAIT=64 -> snow pulses once, 64 cycles after entering WAIT_SLOT; write completes despite vram_read=1.
REQ-042 reset_l pulsed low during WAIT_SLOT -> outputs take reset values immediately; no RAM write occurs.
